// File: rtl/td4_exec_unit.sv
// TD4 execution datapath: adder, A/B/OUT/PC registers, carry flag and IN_PORT synchroniser.
// Define TD4_HALT_EN to latch HALTED on a self-jump and freeze state until reset.
module td4_exec_unit #(
    parameter logic [3:0] RESET_PC = 4'h0
) (
    input  logic       CLK,
    input  logic       N_RESET,
    input  logic       EN,
    input  logic [3:0] IM,
    input  logic [3:0] LOAD,
    input  logic [1:0] SEL,
    input  logic [3:0] IN_PORT,
    output logic [3:0] PC,
    output logic       CFLAG,
    output logic [3:0] OUT_PORT,
    output logic [3:0] A_REG,
    output logic [3:0] B_REG,
    output logic       HALTED
);

    logic [3:0] pc_q, pc_d;
    logic [3:0] a_q, a_d;
    logic [3:0] b_q, b_d;
    logic [3:0] out_q, out_d;
    logic       c_q, c_d;
    logic [3:0] in_s1_q, in_s2_q;

    logic [3:0] src;
    logic [4:0] sum;
    logic       any_load;
    logic       step;
    logic       halted;

    // Synchroniser runs every cycle, independent of EN and HALTED.
    always_ff @(posedge CLK) begin
        if (!N_RESET) begin
            in_s1_q <= 4'h0;
            in_s2_q <= 4'h0;
        end else begin
            in_s1_q <= IN_PORT;
            in_s2_q <= in_s1_q;
        end
    end

    assign any_load = |LOAD;

    // With no destination the sum is forced to zero so an undriven SEL/IM never reaches state.
    always_comb begin
        src = 4'h0;
        sum = 5'h00;
        if (any_load) begin
            case (SEL)
                2'b00:   src = a_q;
                2'b01:   src = b_q;
                2'b10:   src = in_s2_q;
                default: src = 4'h0;
            endcase
            sum = {1'b0, src} + {1'b0, IM};
        end
    end

`ifdef TD4_HALT_EN
    logic halted_q, halted_d;

    always_comb begin
        halted_d = halted_q;
        if (EN && !halted_q && (LOAD == 4'b1000) && (sum[3:0] == pc_q)) begin
            halted_d = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!N_RESET) begin
            halted_q <= 1'b0;
        end else begin
            halted_q <= halted_d;
        end
    end

    assign halted = halted_q;
`else
    assign halted = 1'b0;
`endif

    assign step = EN && !halted;

    always_comb begin
        pc_d  = pc_q;
        a_d   = a_q;
        b_d   = b_q;
        out_d = out_q;
        c_d   = c_q;
        if (step) begin
            if (LOAD[0]) a_d   = sum[3:0];
            if (LOAD[1]) b_d   = sum[3:0];
            if (LOAD[2]) out_d = sum[3:0];
            pc_d = LOAD[3] ? sum[3:0] : pc_q + 4'h1;
            c_d  = sum[4];
        end
    end

    always_ff @(posedge CLK) begin
        if (!N_RESET) begin
            pc_q  <= RESET_PC;
            a_q   <= 4'h0;
            b_q   <= 4'h0;
            out_q <= 4'h0;
            c_q   <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            a_q   <= a_d;
            b_q   <= b_d;
            out_q <= out_d;
            c_q   <= c_d;
        end
    end

    assign PC       = pc_q;
    assign CFLAG    = c_q;
    assign OUT_PORT = out_q;
    assign A_REG    = a_q;
    assign B_REG    = b_q;
    assign HALTED   = halted;

endmodule

// File: tb/tb_td4_exec_unit.sv
// Self-checking bench for td4_exec_unit: directed scenarios plus randomized run against
// an instruction-level reference model.
module tb_td4_exec_unit;

    logic       clk;
    logic       n_reset;
    logic       en;
    logic [3:0] im;
    logic [3:0] load;
    logic [1:0] sel;
    logic [3:0] in_port;
    logic [3:0] pc;
    logic       cflag;
    logic [3:0] out_port;
    logic [3:0] a_reg;
    logic [3:0] b_reg;
    logic       halted;

    int checks = 0;
    int failures = 0;

    td4_exec_unit #(.RESET_PC(4'h3)) dut (
        .CLK     (clk),
        .N_RESET (n_reset),
        .EN      (en),
        .IM      (im),
        .LOAD    (load),
        .SEL     (sel),
        .IN_PORT (in_port),
        .PC      (pc),
        .CFLAG   (cflag),
        .OUT_PORT(out_port),
        .A_REG   (a_reg),
        .B_REG   (b_reg),
        .HALTED  (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [17:0] act;
    assign act = {pc, cflag, out_port, a_reg, b_reg, halted};

    // Reference state: a processor executing one instruction per enabled step.
    int m_pc, m_a, m_b, m_out, m_c, m_halt, m_s1, m_s2;

    function automatic logic [17:0] exp_vec();
        return {m_pc[3:0], m_c[0], m_out[3:0], m_a[3:0], m_b[3:0], m_halt[0]};
    endfunction

    task automatic model_edge();
        int src;
        int s;
        if (!n_reset) begin
            m_pc = 3; m_a = 0; m_b = 0; m_out = 0; m_c = 0; m_halt = 0; m_s1 = 0; m_s2 = 0;
            return;
        end
        if (en && !m_halt) begin
            s = 0;
            if (load != 4'b0000) begin
                if (sel == 2'd0)      src = m_a;
                else if (sel == 2'd1) src = m_b;
                else if (sel == 2'd2) src = m_s2;
                else                  src = 0;
                s = src + int'(im);
            end
`ifdef TD4_HALT_EN
            if (load == 4'b1000 && (s % 16) == m_pc) m_halt = 1;
`endif
            if (load[0]) m_a = s % 16;
            if (load[1]) m_b = s % 16;
            if (load[2]) m_out = s % 16;
            m_pc = load[3] ? s % 16 : (m_pc + 1) % 16;
            m_c  = (s >= 16) ? 1 : 0;
        end
        m_s2 = m_s1;
        m_s1 = int'(in_port);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic drive(input logic e, input logic [3:0] l, input logic [1:0] s,
                         input logic [3:0] i);
        en = e; load = l; sel = s; im = i;
    endtask

    task automatic do_reset();
        n_reset = 1'b0;
        cycle();
        n_reset = 1'b1;
    endtask

    task automatic test_reset();
        n_reset = 1'b0;
        drive(1'b1, 4'b1111, 2'b11, 4'h9);
        cycle();
        checks++;
        if (act !== 18'({4'h3, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0})) begin
            failures++;
            $display("FAIL reset_state: got %h expected %h", act,
                     18'({4'h3, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0}));
        end
        n_reset = 1'b1;
    endtask

    task automatic test_pc_wrap();
        logic [3:0] want;
        for (int i = 0; i < 14; i++) begin
            drive(1'b1, 4'b0000, 2'bxx, 4'hx);
            cycle();
            want = 4'(3 + i + 1);
            checks++;
            if (pc !== want || cflag !== 1'b0 || act !== exp_vec()) begin
                failures++;
                $display("FAIL pc_wrap[%0d]: got pc=%h c=%b expected pc=%h c=0", i, pc, cflag,
                         want);
            end
        end
    endtask

    task automatic test_carry();
        drive(1'b1, 4'b0001, 2'b11, 4'h9);
        cycle();
        drive(1'b1, 4'b0001, 2'b00, 4'h8);
        cycle();
        checks++;
        if (a_reg !== 4'h1 || cflag !== 1'b1 || act !== exp_vec()) begin
            failures++;
            $display("FAIL carry_add: got a=%h c=%b expected a=1 c=1", a_reg, cflag);
        end
        drive(1'b1, 4'b0000, 2'b00, 4'hF);
        cycle();
        checks++;
        if (cflag !== 1'b0 || act !== exp_vec()) begin
            failures++;
            $display("FAIL carry_clear: got c=%b expected c=0", cflag);
        end
    endtask

    task automatic test_in_port();
        in_port = 4'h0;
        drive(1'b1, 4'b0000, 2'b00, 4'h0);
        repeat (3) cycle();
        in_port = 4'h5;
        cycle();
        drive(1'b1, 4'b0100, 2'b10, 4'h0);
        cycle();
        checks++;
        if (out_port !== 4'h0 || act !== exp_vec()) begin
            failures++;
            $display("FAIL in_sync_early: got out=%h expected out=0", out_port);
        end
        cycle();
        checks++;
        if (out_port !== 4'h5 || act !== exp_vec()) begin
            failures++;
            $display("FAIL in_sync_out: got out=%h expected out=5", out_port);
        end
    endtask

    task automatic test_enable_hold();
        logic [17:0] snap;
        drive(1'b1, 4'b0011, 2'b11, 4'h6);
        cycle();
        snap = exp_vec();
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 4'b1111, 2'($urandom_range(0, 3)), 4'($urandom));
            cycle();
            checks++;
            if (act !== snap) begin
                failures++;
                $display("FAIL enable_hold[%0d]: got %h expected %h", i, act, snap);
            end
        end
        n_reset = 1'b0;
        drive(1'b1, 4'b0001, 2'b11, 4'hF);
        cycle();
        n_reset = 1'b1;
        checks++;
        if (a_reg !== 4'h0 || pc !== 4'h3 || act !== exp_vec()) begin
            failures++;
            $display("FAIL reset_priority: got a=%h pc=%h expected a=0 pc=3", a_reg, pc);
        end
    endtask

    task automatic test_multi_load();
        logic [3:0] pc0, out0;
        drive(1'b1, 4'b0100, 2'b11, 4'h2);
        cycle();
        pc0 = 4'(m_pc); out0 = 4'(m_out);
        drive(1'b1, 4'b0011, 2'b11, 4'hA);
        cycle();
        checks++;
        if (a_reg !== 4'hA || b_reg !== 4'hA || out_port !== out0 || pc !== pc0 + 4'h1
            || act !== exp_vec()) begin
            failures++;
            $display("FAIL multi_load: got a=%h b=%h out=%h pc=%h expected a=a b=a out=%h pc=%h",
                     a_reg, b_reg, out_port, pc, out0, pc0 + 4'h1);
        end
    endtask

    task automatic test_self_jump();
        do_reset();
        drive(1'b1, 4'b1000, 2'b11, 4'h7);
        cycle();
        for (int i = 0; i < 4; i++) begin
            if (i > 0) drive(1'b1, 4'($urandom_range(1, 15)), 2'b11, 4'($urandom));
            cycle();
            checks++;
`ifdef TD4_HALT_EN
            if (pc !== 4'h7 || halted !== 1'b1 || act !== exp_vec()) begin
                failures++;
                $display("FAIL self_jump[%0d]: got pc=%h halted=%b expected pc=7 halted=1",
                         i, pc, halted);
            end
`else
            if (i == 0 && (pc !== 4'h7 || halted !== 1'b0 || cflag !== 1'b0)) begin
                failures++;
                $display("FAIL self_jump[%0d]: got pc=%h halted=%b expected pc=7 halted=0",
                         i, pc, halted);
            end else if (i > 0 && act !== exp_vec()) begin
                failures++;
                $display("FAIL self_jump[%0d]: got %h expected %h", i, act, exp_vec());
            end
`endif
            if (i == 0) drive(1'b1, 4'b1000, 2'b11, 4'h7);
        end
        do_reset();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            n_reset = ($urandom_range(0, 39) != 0);
            en      = ($urandom_range(0, 3) != 0);
            load    = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom);
            sel     = 2'($urandom);
            im      = 4'($urandom);
            in_port = 4'($urandom);
            cycle();
            checks++;
            if (act !== exp_vec()) begin
                failures++;
                $display("FAIL random[%0d]: got %h expected %h", i, act, exp_vec());
            end
        end
        n_reset = 1'b1;
    endtask

    initial begin
        n_reset = 1'b0;
        drive(1'b0, 4'b0000, 2'b00, 4'h0);
        in_port = 4'h0;
        test_reset();
        test_pc_wrap();
        test_carry();
        test_in_port();
        test_enable_hold();
        test_multi_load();
        test_self_jump();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
